// File: rtl/arith_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A divide by zero skips the iterations and returns all-ones / dividend.
module arith_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   // After each restore step the partial remainder is below the divisor, so
   // WIDTH bits hold it; only the shifted value needs the extra bit.
   logic [WIDTH-1:0] part_q, part_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [WIDTH-1:0] dq_q, dq_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] part_next;
   logic             last_iter;

   // Next-state and datapath: one shift / trial-subtract / restore step per cycle.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      count_d     = count_q;
      part_d      = part_q;
      dq_d        = dq_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dbz_d       = dbz_q;

      shifted   = {part_q, dq_q[WIDTH-1]};
      diff      = shifted - {1'b0, divisor_q};
      q_bit     = ~diff[WIDTH];
      part_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      last_iter = (count_q == CW'(WIDTH - 1));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  divisor_d = divisor;
                  dq_d      = dividend;
                  part_d    = '0;
                  count_d   = '0;
                  dbz_d     = 1'b0;
                  busy_d    = 1'b1;
                  state_d   = S_DIVIDE;
               end else begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DIVIDE: begin
            part_d  = part_next;
            dq_d    = {dq_q[WIDTH-2:0], q_bit};
            count_d = count_q + CW'(1);
            if (last_iter) begin
               quotient_d  = {dq_q[WIDTH-2:0], q_bit};
               remainder_d = part_next;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over any pending start.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         part_q      <= '0;
         dq_q        <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         part_q      <= part_d;
         dq_q        <= dq_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_divider.sv
// Self-checking bench for arith_divider: directed cases plus a random sweep
// compared against plain integer division.
module tb_arith_divider;

   localparam int WIDTH = 8;
   localparam int NORMAL_LAT = WIDTH + 1;
   localparam int TIMEOUT = 40;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   // Expected held outputs from the previous completed operation.
   int hold_q = 0;
   int hold_r = 0;

   arith_divider #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain arithmetic reference, including the divide-by-zero rule.
   function automatic void ref_div(input int a, input int b,
                                   output int q, output int r, output int z);
      if (b == 0) begin
         q = (1 << WIDTH) - 1;
         r = a;
         z = 1;
      end else begin
         q = a / b;
         r = a % b;
         z = 0;
      end
   endfunction

   // One operation from IDLE. With glitch set, start is re-pulsed with a
   // different divisor during the 3rd and 8th iteration edges.
   task automatic run_div(input int a, input int b, input bit glitch,
                          input bit detail);
      int q, r, z, c, lat;
      ref_div(a, b, q, r, z);
      lat = (b == 0) ? 1 : NORMAL_LAT;
      dividend = WIDTH'(a);
      divisor  = WIDTH'(b);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
      c = 1;
      while (!done && c < TIMEOUT) begin
         if (detail) begin
            check("busy_during", int'(busy), 1);
            check("q_hold", int'(quotient), hold_q);
            check("r_hold", int'(remainder), hold_r);
         end
         if (glitch && (c == 3 || c == 8)) begin
            start   = 1'b1;
            divisor = WIDTH'(3);
         end else begin
            start = 1'b0;
         end
         tick();
         c++;
      end
      start = 1'b0;
      check($sformatf("latency %0d/%0d", a, b), c, lat);
      check($sformatf("quot %0d/%0d", a, b), int'(quotient), q);
      check($sformatf("rem %0d/%0d", a, b), int'(remainder), r);
      check($sformatf("dbz %0d/%0d", a, b), int'(div_by_zero), z);
      if (detail) check("busy_at_done", int'(busy), 0);
      tick();
      check("done_one_cycle", int'(done), 0);
      hold_q = q;
      hold_r = r;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_q"}, int'(quotient), 0);
      check({tag, "_r"}, int'(remainder), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_dbz"}, int'(div_by_zero), 0);
   endtask

   initial begin
      int a, b, last_done, gap;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      reset = 1'b0;
      check_cleared("reset");

      // Basic case with per-cycle busy and output-hold checks.
      run_div(200, 7, 1'b0, 1'b1);
      // Extremes, and outputs held from the first while the second runs.
      run_div(255, 1, 1'b0, 1'b1);
      run_div(5, 9, 1'b0, 1'b1);
      // Divide by zero, then a normal op clears the flag.
      run_div(8'h37, 0, 1'b0, 1'b1);
      run_div(100, 10, 1'b0, 1'b1);
      // Start pulses during the division are ignored.
      run_div(100, 10, 1'b1, 1'b1);

      // Reset on the 4th iteration edge aborts with no done pulse.
      dividend = 8'd200;
      divisor  = 8'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_cleared("mid_reset");
      for (int i = 0; i < 8; i++) begin
         check("no_done_after_reset", int'(done), 0);
         tick();
      end
      hold_q = 0;
      hold_r = 0;
      run_div(9, 2, 1'b0, 1'b1);

      // Start held high: back-to-back operations spaced WIDTH+2 cycles.
      dividend  = 8'd50;
      divisor   = 8'd6;
      start     = 1'b1;
      last_done = -1;
      gap       = 0;
      for (int cyc = 0; cyc < 35; cyc++) begin
         tick();
         if (done) begin
            check("b2b_quot", int'(quotient), 8);
            check("b2b_rem", int'(remainder), 2);
            if (last_done >= 0) gap = cyc - last_done;
            last_done = cyc;
         end
      end
      start = 1'b0;
      check("b2b_spacing", gap, WIDTH + 2);
      repeat (WIDTH + 3) tick();
      hold_q = 8;
      hold_r = 2;

      // Random sweep with forced corners mixed in.
      for (int i = 0; i < 3000; i++) begin
         a = int'($urandom_range(255, 0));
         b = int'($urandom_range(255, 0));
         if ($urandom_range(15, 0) == 0) b = 0;
         if ($urandom_range(31, 0) == 0) a = 0;
         if ($urandom_range(31, 0) == 0) a = 255;
         if ($urandom_range(31, 0) == 0) b = 1;
         run_div(a, b, ($urandom_range(7, 0) == 0), (i < 50));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
